sd_block_reader: RTL and testbench

//  Sequences sd_controller to read a run of consecutive 512-byte blocks.

---
 rtl/sd_block_reader_pkg.sv | 9 +
 rtl/sd_block_reader_watchdog.sv | 18 +
 rtl/sd_block_reader.sv | 148 ++++++++++++++
 tb/tb_sd_block_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_block_reader_pkg.sv
// sd_block_reader_pkg: reader state encoding, block geometry and address mapping
package sd_block_reader_pkg;
  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_BLOCK_SHIFT = 9;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, RECV, NEXT, FINISH, ERR} state_t;
  function automatic logic [31:0] sd_addr(input logic [31:0] b, input logic byte_addr);
    return byte_addr ? b << SD_BLOCK_SHIFT : b;
  endfunction
endpackage

// File: rtl/sd_block_reader_watchdog.sv
// sd_block_reader_watchdog: counts idle cycles while enabled, flags expiry after TIMEOUT_CYC
module sd_block_reader_watchdog #(
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic kick,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (kick || !en) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = en && (cnt_q == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/sd_block_reader.sv
// sd_block_reader: sequences sd_controller through a run of consecutive 512-byte block reads
module sd_block_reader
  import sd_block_reader_pkg::*;
#(
  parameter bit BYTE_ADDR   = 1'b1,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_block,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             sd_ready,
  input  logic             sd_byte_available,
  input  logic [7:0]       sd_dout,
  output logic             sd_rd,
  output logic [31:0]      sd_address,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [8:0]       byte_index,
  output logic             block_done,
  output logic             busy,
  output logic             done,
  output logic             error
);
  state_t state_q, state_d;
  logic [31:0] blk_q, blk_d, addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [8:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [7:0] din_q, dout_q, dout_d;
  logic av_q, av_prev_q, rd_q, rd_d, valid_q, valid_d, bdone_q, bdone_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic byte_edge, wd_en, wd_kick, expire;
  assign byte_edge = av_q && !av_prev_q;
  assign wd_en = state_q inside {WAIT_RDY, ISSUE, RECV};
  assign wd_kick = byte_edge || (state_d != state_q);
  sd_block_reader_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk(clk), .reset(reset), .en(wd_en), .kick(wd_kick), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    addr_d = addr_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    dout_d = dout_q;
    rd_d = 1'b0;
    valid_d = 1'b0;
    bdone_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        blk_d = base_block;
        rem_d = num_blocks;
        addr_d = sd_addr(base_block, BYTE_ADDR);
        err_d = 1'b0;
        busy_d = 1'b1;
        state_d = (num_blocks == '0) ? FINISH : WAIT_RDY;
      end
      WAIT_RDY: begin
        rd_d = sd_ready;
        state_d = sd_ready ? ISSUE : WAIT_RDY;
      end
      ISSUE: begin
        rd_d = sd_ready;
        cnt_d = '0;
        state_d = sd_ready ? ISSUE : RECV;
      end
      RECV: if (byte_edge) begin
        dout_d = din_q;
        valid_d = 1'b1;
        idx_d = cnt_q;
        cnt_d = cnt_q + 9'd1;
        bdone_d = cnt_q == 9'(SD_BLOCK_BYTES - 1);
        state_d = bdone_d ? NEXT : RECV;
      end
      NEXT: begin
        rem_d = rem_q - CNT_W'(1);
        blk_d = blk_q + 32'd1;
        addr_d = sd_addr(blk_q + 32'd1, BYTE_ADDR);
        state_d = (rem_q == CNT_W'(1)) ? FINISH : WAIT_RDY;
      end
      FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // the watchdog only runs in states that wait on the card, so expiry always aborts
    if (expire) begin
      state_d = ERR;
      rd_d = 1'b0;
      busy_d = 1'b0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      blk_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      dout_q <= '0;
      din_q <= '0;
      av_q <= 1'b0;
      av_prev_q <= 1'b0;
      rd_q <= 1'b0;
      valid_q <= 1'b0;
      bdone_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dout_q <= dout_d;
      din_q <= sd_dout;
      av_q <= sd_byte_available;
      av_prev_q <= av_q;
      rd_q <= rd_d;
      valid_q <= valid_d;
      bdone_q <= bdone_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign sd_rd = rd_q;
  assign sd_address = addr_q;
  assign byte_out = dout_q;
  assign byte_valid = valid_q;
  assign byte_index = idx_q;
  assign block_done = bdone_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: SD controller model plus byte scoreboard driving SDSC and SDHC readers in lockstep
module tb_sd_block_reader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] base_block = '0;
  logic [15:0] num_blocks = '0;
  logic sd_ready, sd_byte_available;
  logic [7:0] sd_dout;
  logic rd0, rd1, bv0, bv1, bd0, bd1, busy0, busy1, done0, done1, err0, err1;
  logic [31:0] addr0, addr1;
  logic [7:0] bo0, bo1;
  logic [8:0] bi0, bi1;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sd_block_reader #(.BYTE_ADDR(1'b1), .TIMEOUT_CYC(1000), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .start(start), .base_block(base_block), .num_blocks(num_blocks),
    .sd_ready(sd_ready), .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .sd_rd(rd0), .sd_address(addr0), .byte_out(bo0), .byte_valid(bv0), .byte_index(bi0),
    .block_done(bd0), .busy(busy0), .done(done0), .error(err0)
  );
  sd_block_reader #(.BYTE_ADDR(1'b0), .TIMEOUT_CYC(1000), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .start(start), .base_block(base_block), .num_blocks(num_blocks),
    .sd_ready(sd_ready), .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .sd_rd(rd1), .sd_address(addr1), .byte_out(bo1), .byte_valid(bv1), .byte_index(bi1),
    .block_done(bd1), .busy(busy1), .done(done1), .error(err1)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] pat(input logic [31:0] b, input int n);
    logic [8:0] nn;
    nn = 9'(n);
    return nn[7:0] ^ b[7:0] ^ (nn[8] ? 8'hA5 : 8'h00);
  endfunction
  function automatic logic [63:0] outs0();
    return {9'b0, rd0, addr0, bo0, bv0, bi0, bd0, busy0, done0, err0};
  endfunction
  function automatic logic [63:0] outs1();
    return {9'b0, rd1, addr1, bo1, bv1, bi1, bd1, busy1, done1, err1};
  endfunction
  typedef struct {int due; logic [7:0] d; int idx;} ev_t;
  ev_t q[$];
  logic [31:0] addr_log0[$], addr_log1[$];
  logic [7:0] cap[512];
  int rdy_delay = 2, acc_delay = 0, stall_at = -1;
  logic m_abort = 1'b1;
  logic [31:0] m_blk = '0;
  int nbytes = 0, rd_cmds = 0, done_cnt = 0, lastv = 0, rd_len = 0, rd_last = 0;
  logic rd_prev = 1'b0;
  // card model: ready after rdy_delay, accepts rd after acc_delay, then 512 strobes of 4 cycles each
  initial begin
    int ph, wt, acnt, nb, tk;
    ph = 0; wt = 0; acnt = 0; nb = 0; tk = 0;
    sd_ready = 1'b0; sd_byte_available = 1'b0; sd_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (m_abort) begin
        ph = 0; wt = rdy_delay; sd_ready = 1'b0; sd_byte_available = 1'b0;
      end else begin
        case (ph)
          0: if (wt > 0) wt--; else begin sd_ready = 1'b1; ph = 1; end
          1: if (rd0) begin
            chk("addr_sdsc", addr0, {32'd0, m_blk << 9});
            chk("addr_sdhc", addr1, {32'd0, m_blk});
            acnt = acc_delay; ph = 3;
          end
          2: if (nb == 512) begin
            ph = 0; wt = rdy_delay; m_blk = m_blk + 32'd1;
          end else if (nb != stall_at) begin
            if (tk == 0) begin
              sd_dout = pat(m_blk, nb); sd_byte_available = 1'b1;
              q.push_back('{cyc + 2, sd_dout, nb});
            end
            if (tk == 2) begin sd_byte_available = 1'b0; nb++; end
            tk = (tk + 1) % 4;
          end
          default: ;
        endcase
        if (ph == 3) begin
          if (acnt == 0) begin sd_ready = 1'b0; ph = 2; tk = 0; nb = 0; end
          else acnt--;
        end
      end
    end
  end
  always @(negedge clk) begin : cmp
    logic ev;
    ev = q.size() > 0 && q[0].due == cyc;
    chk("byte_valid0", {63'd0, bv0}, {63'd0, ev});
    chk("byte_valid1", {63'd0, bv1}, {63'd0, ev});
    if (ev) begin
      chk("byte_out0", {56'd0, bo0}, {56'd0, q[0].d});
      chk("byte_out1", {56'd0, bo1}, {56'd0, q[0].d});
      chk("byte_index0", {55'd0, bi0}, 64'(q[0].idx));
      chk("byte_index1", {55'd0, bi1}, 64'(q[0].idx));
      chk("block_done0", {63'd0, bd0}, {63'd0, q[0].idx == 511});
      chk("block_done1", {63'd0, bd1}, {63'd0, q[0].idx == 511});
      cap[q[0].idx] = bo0;
      nbytes++;
      lastv = cyc;
      void'(q.pop_front());
    end else begin
      chk("block_done_quiet", {62'd0, bd0, bd1}, 64'd0);
    end
    if (rd0) rd_len++;
    else if (rd_len > 0) begin
      chk("rd_hold", 64'(rd_len), 64'(acc_delay + 1));
      rd_last = rd_len; rd_len = 0;
    end
    if (rd0 && !rd_prev) begin
      rd_cmds++; addr_log0.push_back(addr0); addr_log1.push_back(addr1);
    end
    rd_prev = rd0;
    if (done0) begin
      done_cnt++;
      chk("done_not_busy", {63'd0, busy0}, 64'd0);
    end
  end
  task automatic go(input logic [31:0] b, input logic [15:0] n, input int rdy, input int acc, input int stall);
    @(negedge clk);
    rdy_delay = rdy; acc_delay = acc; stall_at = stall; m_blk = b; m_abort = 1'b1;
    @(negedge clk);
    m_abort = 1'b0; nbytes = 0; rd_cmds = 0; done_cnt = 0;
    addr_log0.delete(); addr_log1.delete();
    start = 1'b1; base_block = b; num_blocks = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_end(input int lim);
    int t;
    t = 0;
    while (!done0 && !err0 && t < lim) begin @(negedge clk); t++; end
    chk("end_in_budget", {63'd0, t < lim}, 64'd1);
  endtask
  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while (nbytes < n && t < 5000) begin @(negedge clk); t++; end
    chk("bytes_in_budget", {63'd0, t < 5000}, 64'd1);
  endtask
  initial begin
    logic b1, b2, b3, d1, d2, d3;
    repeat (2) @(negedge clk);
    chk("reset_outs0", outs0(), 64'd0);
    chk("reset_outs1", outs1(), 64'd0);
    reset = 1'b0;
    go(32'd5, 16'd1, 2, 0, -1);
    chk("t1_busy", {63'd0, busy0}, 64'd1);
    wait_end(6000);
    chk("t1_done", {62'd0, done0, err0}, 64'd2);
    chk("t1_done_lag", {63'd0, (cyc - lastv) inside {[1:3]}}, 64'd1);
    chk("t1_bytes", 64'(nbytes), 64'd512);
    chk("t1_rd_cmds", 64'(rd_cmds), 64'd1);
    chk("t1_addr_sdsc", {32'd0, addr_log0[0]}, 64'h0000_0A00);
    chk("t1_addr_sdhc", {32'd0, addr_log1[0]}, 64'd5);
    chk("t1_byte0", {56'd0, cap[0]}, 64'h05);
    chk("t1_byte511", {56'd0, cap[511]}, 64'h5F);
    @(negedge clk);
    chk("t1_done_pulse", {62'd0, done0, busy0}, 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    go(32'hFFFF_FFFF, 16'd2, 2, 0, -1);
    wait_end(12000);
    chk("t2_done", {62'd0, done0, err0}, 64'd2);
    chk("t2_bytes", 64'(nbytes), 64'd1024);
    chk("t2_rd_cmds", 64'(rd_cmds), 64'd2);
    chk("t2_addr_sdhc_a", {32'd0, addr_log1[0]}, 64'hFFFF_FFFF);
    chk("t2_addr_sdhc_b", {32'd0, addr_log1[1]}, 64'd0);
    chk("t2_addr_sdsc_a", {32'd0, addr_log0[0]}, 64'hFFFF_FE00);
    chk("t2_addr_sdsc_b", {32'd0, addr_log0[1]}, 64'd0);
    go(32'd7, 16'd0, 2, 0, -1);
    b1 = busy0; d1 = done0;
    @(negedge clk); b2 = busy0; d2 = done0;
    @(negedge clk); b3 = busy0; d3 = done0;
    chk("t3_done_once", 64'(int'(d1) + int'(d2) + int'(d3)), 64'd1);
    chk("t3_done_early", {63'd0, d1 | d2}, 64'd1);
    chk("t3_busy_short", {63'd0, (int'(b1) + int'(b2) + int'(b3)) <= 1}, 64'd1);
    repeat (5) @(negedge clk);
    chk("t3_no_rd", 64'(rd_cmds), 64'd0);
    chk("t3_no_bytes", 64'(nbytes), 64'd0);
    go(32'd9, 16'd1, 2, 0, 100);
    wait_end(6000);
    chk("t4_error", {61'd0, err0, rd0, busy0}, 64'd4);
    chk("t4_error_sdhc", {63'd0, err1}, 64'd1);
    chk("t4_bytes", 64'(nbytes), 64'd100);
    chk("t4_timeout_lag", {63'd0, (cyc - lastv) inside {[990:1010]}}, 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_error_sticky", {63'd0, err0}, 64'd1);
    go(32'd9, 16'd1, 2, 0, -1);
    chk("t4_error_cleared", {62'd0, err0, busy0}, 64'd1);
    wait_end(6000);
    chk("t4_recover", {62'd0, done0, err0}, 64'd2);
    chk("t4_recover_bytes", 64'(nbytes), 64'd512);
    go(32'd3, 16'd1, 10, 10, -1);
    wait_bytes(50);
    start = 1'b1; base_block = 32'd77; num_blocks = 16'd5;
    @(negedge clk);
    start = 1'b0;
    chk("t5_still_busy", {63'd0, busy0}, 64'd1);
    wait_end(6000);
    chk("t5_done", {62'd0, done0, err0}, 64'd2);
    chk("t5_bytes", 64'(nbytes), 64'd512);
    chk("t5_rd_len", 64'(rd_last), 64'd11);
    chk("t5_addr", {32'd0, addr_log1[0]}, 64'd3);
    repeat (20) @(negedge clk);
    chk("t5_not_queued", {31'd0, busy0, 32'(rd_cmds)}, 64'd1);
    go(32'd1, 16'd2, 2, 0, -1);
    wait_bytes(300);
    #3;
    reset = 1'b1; m_abort = 1'b1; q.delete();
    #1;
    chk("t6_reset_outs0", outs0(), 64'd0);
    chk("t6_reset_outs1", outs1(), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_held", outs0(), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle", {62'd0, busy0, rd0}, 64'd0);
    go(32'd2, 16'd1, 2, 0, -1);
    wait_end(6000);
    chk("t6_restart", {62'd0, done0, err0}, 64'd2);
    chk("t6_restart_bytes", 64'(nbytes), 64'd512);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
